// File: rtl/fifo_wr_arbiter.sv
// Write-side controller of the async FIFO: round-robin arbitration onto the single write port,
// binary/Gray write pointers, and full/occupancy derived from the synchronized Gray read pointer.
module fifo_wr_arbiter #(
    parameter int ADDR = 4,
    parameter int DATA = 8,
    parameter int NREQ = 4
) (
    input  logic                 wr_clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*DATA-1:0] req_data_i,
    input  logic [ADDR:0]        sync_rd_ptr_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic                 wr_en_o,
    output logic [ADDR-1:0]      wr_addr_o,
    output logic [DATA-1:0]      wr_data_o,
    output logic [ADDR:0]        gr_wr_ptr_o,
    output logic                 full_o,
    output logic [ADDR:0]        wr_level_o
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [ADDR:0]   bin_q, bin_d;
    logic [LW-1:0]   last_q;
    logic            wr_en_q;
    logic [ADDR-1:0] wr_addr_q;
    logic [DATA-1:0] wr_data_q;
    logic [ADDR:0]   gray_q;
    logic            full_q, full_d;
    logic [ADDR:0]   level_q, level_d;

    logic            accept;
    logic [LW-1:0]   gnt_idx;
    logic [ADDR:0]   rd_bin;
    logic [ADDR:0]   gray_next;
    int              idx;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        gnt_o   = '0;
        gnt_idx = '0;
        accept  = 1'b0;
        idx     = 0;
        if (rst_i && !full_q) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (int'(last_q) + k) % NREQ;
                if (!accept && req_i[idx]) begin
                    accept       = 1'b1;
                    gnt_o[idx]   = 1'b1;
                    gnt_idx      = LW'(idx);
                end
            end
        end
    end

    always_comb begin
        rd_bin = '0;
        for (int i = 0; i <= ADDR; i++) begin
            rd_bin[i] = ^(sync_rd_ptr_i >> i);
        end
    end

    // Full when the next Gray pointer equals the read pointer with its two MSBs inverted.
    always_comb begin
        bin_d     = bin_q + {{ADDR{1'b0}}, accept};
        gray_next = bin_d ^ (bin_d >> 1);
        full_d    = (gray_next == {~sync_rd_ptr_i[ADDR:ADDR-1], sync_rd_ptr_i[ADDR-2:0]});
        level_d   = bin_d - rd_bin;
    end

    always_ff @(posedge wr_clk_i) begin
        if (!rst_i) begin
            bin_q     <= '0;
            last_q    <= LW'(NREQ - 1);
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            gray_q    <= '0;
            full_q    <= 1'b0;
            level_q   <= '0;
        end else begin
            bin_q   <= bin_d;
            // Published from the pre-edge pointer so it never leads the memory write.
            gray_q  <= bin_q ^ (bin_q >> 1);
            full_q  <= full_d;
            level_q <= level_d;
            wr_en_q <= accept;
            if (accept) begin
                wr_addr_q <= bin_q[ADDR-1:0];
                wr_data_q <= req_data_i[int'(gnt_idx)*DATA +: DATA];
                last_q    <= gnt_idx;
            end
        end
    end

    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign gr_wr_ptr_o = gray_q;
    assign full_o      = full_q;
    assign wr_level_o  = level_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a cycle model predicts grants and pushes expected writes to a
// scoreboard that a negedge monitor drains; each scenario task also checks its own milestones.
module tb_fifo_wr_arbiter;
    localparam int ADDR = 4;
    localparam int DATA = 8;
    localparam int NREQ = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [31:0]   req_data;
    logic [4:0]    rd_bin;
    logic [4:0]    sync_rd;
    logic [3:0]    gnt;
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [7:0]    wr_data;
    logic [4:0]    gr_wr_ptr;
    logic          full;
    logic [4:0]    wr_level;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign sync_rd = rd_bin ^ (rd_bin >> 1);

    fifo_wr_arbiter #(.ADDR(ADDR), .DATA(DATA), .NREQ(NREQ)) dut (
        .wr_clk_i      (clk),
        .rst_i         (rst),
        .req_i         (req),
        .req_data_i    (req_data),
        .sync_rd_ptr_i (sync_rd),
        .gnt_o         (gnt),
        .wr_en_o       (wr_en),
        .wr_addr_o     (wr_addr),
        .wr_data_o     (wr_data),
        .gr_wr_ptr_o   (gr_wr_ptr),
        .full_o        (full),
        .wr_level_o    (wr_level)
    );

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        sb[$];
    logic [4:0] m_bin = '0;
    logic [4:0] m_gray = '0;
    logic [4:0] m_level = '0;
    logic       m_full = 1'b0;
    int         m_last = 3;

    function automatic logic [3:0] model_gnt();
        if (rst !== 1'b1 || m_full) return 4'b0000;
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (m_last + k) % NREQ;
            if (req[j]) return 4'(1 << j);
        end
        return 4'b0000;
    endfunction

    // Reference model: occupancy counted as writes minus reads, full at exactly 16 entries.
    always @(posedge clk) begin
        logic [3:0] g;
        int         w;
        g = model_gnt();
        if (rst !== 1'b1) begin
            m_bin = '0; m_gray = '0; m_level = '0; m_full = 1'b0; m_last = 3;
            sb.delete();
        end else begin
            m_gray = m_bin ^ (m_bin >> 1);
            if (g != 4'b0000) begin
                w = 0;
                for (int j = 0; j < NREQ; j++) if (g[j]) w = j;
                sb.push_back('{addr: m_bin[3:0], data: req_data[w*8 +: 8]});
                m_bin  = m_bin + 5'd1;
                m_last = w;
            end
            m_level = m_bin - rd_bin;
            m_full  = (m_level == 5'd16);
        end
    end

    always @(negedge clk) begin
        wr_t e;
        tests++;
        if (wr_en !== (sb.size() != 0)) begin
            fails++;
            $display("FAIL mon_wr_en: got %b expected %b", wr_en, sb.size() != 0);
        end
        if (wr_en === 1'b1 && sb.size() != 0) begin
            e = sb.pop_front();
            tests++;
            if (wr_addr !== e.addr || wr_data !== e.data) begin
                fails++;
                $display("FAIL mon_write: got addr %0d data %h expected addr %0d data %h",
                         wr_addr, wr_data, e.addr, e.data);
            end
        end
        tests++;
        if (gr_wr_ptr !== m_gray || full !== m_full || wr_level !== m_level) begin
            fails++;
            $display("FAIL mon_ptrs: got gray %b full %b level %0d expected gray %b full %b level %0d",
                     gr_wr_ptr, full, wr_level, m_gray, m_full, m_level);
        end
    end

    task automatic test_reset();
        rst = 1'b0; req = 4'b1111; rd_bin = '0; req_data = 32'h44332211;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (gnt !== 4'b0000 || wr_en !== 1'b0 || gr_wr_ptr !== 5'd0 || full !== 1'b0 || wr_level !== 5'd0) begin
            fails++;
            $display("FAIL reset_state: got gnt %b wr_en %b gray %b full %b level %0d expected all zero",
                     gnt, wr_en, gr_wr_ptr, full, wr_level);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (gnt !== 4'b0001) begin
            fails++;
            $display("FAIL reset_first_gnt: got %b expected 0001", gnt);
        end
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_single();
        rst = 1'b0; req = 4'b0000; rd_bin = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; req = 4'b0001; req_data = 32'h000000A5;
        #1;
        tests++;
        if (gnt !== 4'b0001) begin
            fails++;
            $display("FAIL single_gnt: got %b expected 0001", gnt);
        end
        @(negedge clk);
        req = 4'b0000;
        #1;
        tests++;
        if (wr_en !== 1'b1 || wr_addr !== 4'd0 || wr_data !== 8'hA5) begin
            fails++;
            $display("FAIL single_t1: got wr_en %b addr %0d data %h expected 1 0 a5", wr_en, wr_addr, wr_data);
        end
        @(negedge clk);
        #1;
        tests++;
        if (gr_wr_ptr !== 5'b00001 || wr_level !== 5'd1 || wr_en !== 1'b0) begin
            fails++;
            $display("FAIL single_t2: got gray %b level %0d wr_en %b expected 00001 1 0", gr_wr_ptr, wr_level, wr_en);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_alt [4];
        exp_alt = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        rst = 1'b0; req = 4'b0000; rd_bin = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; req = 4'b1111; req_data = 32'hD4C3B2A1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            tests++;
            if (gnt !== 4'(1 << (i % 4))) begin
                fails++;
                $display("FAIL rr_all[%0d]: got %b expected %b", i, gnt, 4'(1 << (i % 4)));
            end
        end
        @(negedge clk);
        req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            tests++;
            if (gnt !== exp_alt[i] || gnt !== model_gnt()) begin
                fails++;
                $display("FAIL rr_alt[%0d]: got %b expected %b", i, gnt, exp_alt[i]);
            end
        end
        @(negedge clk);
        req = 4'b0000;
        #1;
        tests++;
        if (wr_level !== 5'd12) begin
            fails++;
            $display("FAIL rr_level: got %0d expected 12", wr_level);
        end
    endtask

    task automatic test_fill_wrap();
        rst = 1'b0; req = 4'b0000; rd_bin = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; req = 4'b0010;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            req_data[15:8] = 8'($urandom);
            #1;
            tests++;
            if (gnt !== 4'b0010 || (i > 0 && wr_addr !== 4'(i - 1))) begin
                fails++;
                $display("FAIL fill[%0d]: got gnt %b addr %0d expected 0010 %0d", i, gnt, wr_addr, i - 1);
            end
        end
        @(negedge clk);
        #1;
        tests++;
        if (gnt !== 4'b0000 || full !== 1'b1 || wr_level !== 5'b10000 || wr_addr !== 4'd15) begin
            fails++;
            $display("FAIL fill_full: got gnt %b full %b level %b addr %0d expected 0000 1 10000 15",
                     gnt, full, wr_level, wr_addr);
        end
        @(negedge clk);
        #1;
        tests++;
        if (gr_wr_ptr !== 5'b11000 || gnt !== 4'b0000 || full !== 1'b1) begin
            fails++;
            $display("FAIL fill_gray: got gray %b gnt %b full %b expected 11000 0000 1", gr_wr_ptr, gnt, full);
        end
        @(negedge clk);
        rd_bin = 5'd1;
        #1;
        tests++;
        if (gnt !== 4'b0000) begin
            fails++;
            $display("FAIL release_same_cycle: got gnt %b expected 0000", gnt);
        end
        @(negedge clk);
        #1;
        tests++;
        if (full !== 1'b0 || wr_level !== 5'd15 || gnt !== 4'b0010) begin
            fails++;
            $display("FAIL release_next: got full %b level %0d gnt %b expected 0 15 0010", full, wr_level, gnt);
        end
        @(negedge clk);
        #1;
        tests++;
        if (wr_en !== 1'b1 || wr_addr !== 4'd0 || full !== 1'b1 || gnt !== 4'b0000) begin
            fails++;
            $display("FAIL wrap: got wr_en %b addr %0d full %b gnt %b expected 1 0 1 0000", wr_en, wr_addr, full, gnt);
        end
        req = 4'b0000;
    endtask

    task automatic test_reset_mid();
        rst = 1'b0; req = 4'b0000; rd_bin = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; req = 4'b1111; req_data = 32'h5A6B7C8D;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (gnt !== 4'b0000) begin
            fails++;
            $display("FAIL mid_rst_gnt: got %b expected 0000", gnt);
        end
        @(negedge clk);
        #1;
        tests++;
        if (wr_en !== 1'b0 || wr_addr !== 4'd0 || wr_data !== 8'd0 || gr_wr_ptr !== 5'd0 || full !== 1'b0 || wr_level !== 5'd0) begin
            fails++;
            $display("FAIL mid_rst_outs: got wr_en %b addr %0d data %h gray %b full %b level %0d expected all zero",
                     wr_en, wr_addr, wr_data, gr_wr_ptr, full, wr_level);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (gnt !== 4'b0001) begin
            fails++;
            $display("FAIL mid_rst_restart: got %b expected 0001", gnt);
        end
        @(negedge clk);
        req = 4'b0000;
    endtask

    task automatic test_simultaneous();
        rst = 1'b0; req = 4'b0000; rd_bin = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; req = 4'b0001; req_data = 32'h000000C3;
        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            tests++;
            if (gnt !== 4'b0001) begin
                fails++;
                $display("FAIL simul_fill[%0d]: got %b expected 0001", i, gnt);
            end
        end
        @(negedge clk);
        rd_bin = 5'd1;
        #1;
        tests++;
        if (wr_level !== 5'd15 || full !== 1'b0 || gnt !== 4'b0001) begin
            fails++;
            $display("FAIL simul_pre: got level %0d full %b gnt %b expected 15 0 0001", wr_level, full, gnt);
        end
        @(negedge clk);
        req = 4'b0000;
        #1;
        tests++;
        if (wr_level !== 5'd15 || full !== 1'b0) begin
            fails++;
            $display("FAIL simul_post: got level %0d full %b expected 15 0", wr_level, full);
        end
    endtask

    initial begin
        rst = 1'b0; req = '0; req_data = '0; rd_bin = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_fill_wrap();
        test_reset_mid();
        test_simultaneous();
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: got %0d pending writes expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side controller for the asynchronous FIFO: arbitrates `NREQ` requesters round-robin onto the single FIFO write port, sequences memory writes, and maintains the binary and Gray write pointers. It runs entirely in the write clock domain. It consumes the two-flop-synchronized Gray read pointer to generate `full` and an occupancy level, and it publishes the Gray write pointer toward the read-domain synchronizer.

## Interface
- `ADDR`, default 4: FIFO address width; depth = 2^ADDR; pointers are ADDR+1 bits.
- `DATA`, default 8: word width.
- `NREQ`, default 4: number of requesters (≥2).

- `wr_clk`  in  1  write-domain clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low; sampled on the rising edge of `wr_clk`.
- `req`  in  NREQ  per-requester write request; held with data until granted.
- `req_data`  in  NREQ*DATA  requester i data at bits [i*DATA +: DATA].
- `sync_rd_ptr`  in  ADDR+1  Gray read pointer, already synchronized into `wr_clk`.
- `gnt`  out  NREQ  one-hot or zero, combinational; request i is accepted in any cycle where `gnt[i]` is high.
- `wr_en`  out  1  registered memory write enable.
- `wr_addr`  out  ADDR  registered memory write address.
- `wr_data`  out  DATA  registered memory write data.
- `gr_wr_ptr`  out  ADDR+1  registered Gray write pointer, sent to the read-domain synchronizer.
- `full`  out  1  registered full flag.
- `wr_level`  out  ADDR+1  registered occupancy as seen from the write side, 0..2^ADDR.

## Operation
- **Internal state:**
  - `bin_ptr`: ADDR+1 binary write pointer.
  - `last`: index of the most recent grant.
  - A one-stage publish register that drives `gr_wr_ptr`.
- **Accept:** `accept = |gnt`.
  - `gnt` is all-zero when `full`=1 or `rst`=0.
  - Otherwise `gnt` selects the first asserted `req` searching `last+1, last+2, …` modulo NREQ.
- **On accept of requester i at an edge:**
  - `wr_en`←1, `wr_addr`←`bin_ptr[ADDR-1:0]`, `wr_data`←`req_data[i]`.
  - `bin_ptr`←`bin_ptr+1`, wrapping modulo 2^(ADDR+1).
  - `last`←i.
- **No accept at an edge:** `wr_en`←0. `wr_addr` and `wr_data` hold their values.
- **Gray publish:** `gr_wr_ptr`←`bin_ptr ^ (bin_ptr>>1)`, using the value of `bin_ptr` before this edge. The published pointer therefore trails `bin_ptr` by one cycle, so it never runs ahead of the memory write.
- **Pointer updates:** let `bin_next = bin_ptr + accept`.
  - `full`←(`gray(bin_next)` == {~`sync_rd_ptr[ADDR:ADDR-1]`, `sync_rd_ptr[ADDR-2:0]`}).
  - `wr_level`←(`bin_next` − `gray2bin(sync_rd_ptr)`), computed modulo 2^(ADDR+1).
- **Reset:** on an edge with `rst`=0, all registers clear: `bin_ptr`, `wr_en`, `wr_addr`, `wr_data`, `gr_wr_ptr`, `full` and `wr_level` go to 0, and `last` goes to NREQ−1. Requester 0 therefore has first priority after reset.
- **Reset mid-operation:** a pending request is not accepted on the reset edge, and in-flight `wr_en` is dropped. The read side is reset concurrently at system level.
- **Simultaneous events:** a grant and a change of `sync_rd_ptr` in the same cycle are both reflected in `full` and `wr_level` at that edge.
- **Wrap-around:** the pointer MSB toggles every 2^ADDR writes, and `wr_addr` wraps 2^ADDR−1→0 with no gap.

## Timing
- Grant to memory write: `gnt` high in cycle t → `wr_en`/`wr_addr`/`wr_data` valid in cycle t+1 → `gr_wr_ptr` reflects the write in cycle t+2.
- Sustained throughput is one accept per cycle while not full.
- `full` rises in the cycle after the grant that fills the FIFO, and no grant occurs in that cycle.
- A `sync_rd_ptr` change in cycle u → `full`/`wr_level` updated in cycle u+1 → grant possible in u+1.
- A requester must hold `req` and `req_data` stable until it sees `gnt`. It may drop `req` after `gnt` at the same edge.

## Test plan
- **Reset:** `rst`=0 for 3 edges with `req`=4'b1111 → `gnt`=0, `wr_en`=0, `gr_wr_ptr`=0, `full`=0, `wr_level`=0. After release, the first `gnt`=4'b0001.
- **Single write latency:** `req`=4'b0001, data 0xA5, `sync_rd_ptr`=0.
  - `gnt`=0001 in cycle t.
  - Cycle t+1: `wr_en`=1, `wr_addr`=0, `wr_data`=0xA5.
  - Cycle t+2: `gr_wr_ptr`=5'b00001, `wr_level`=1.
- **Round-robin:** `req`=4'b1111 held for 8 cycles → `gnt` sequence 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000. With `req`=4'b0101 → alternating 0001/0100.
- **Fill:** `sync_rd_ptr`=0 with continuous requests → 16 grants with `wr_addr` 0..15. Then `full`=1 and `wr_level`=5'b10000, `gnt` stays 0, and `gr_wr_ptr` settles to 5'b11000.
- **Release and wrap:** from full, set `sync_rd_ptr`=5'b00001.
  - Next cycle: `full`=0 and one grant occurs, written with `wr_addr`=0 (wrapped).
  - `full` reasserts on the following cycle.
- **Reset mid-stream and simultaneity:**
  - Assert `rst`=0 during continuous writes → all outputs are 0 at the next edge.
  - Separately, grant in the same cycle as a `sync_rd_ptr` advance at level 15 → `full` stays 0 and `wr_level` stays 15.
